// File: rtl/xuart_pkg.sv
// Shared definitions for the xuart transmitter: FSM encoding, status layout, address decode.
package xuart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned StatRdy  = 0;
    localparam int unsigned StatIdle = 1;
    localparam int unsigned StatOvf  = 2;

    // addr bit selecting data write (0) versus overflow clear (1)
    localparam int unsigned AddrOvfClr = 0;

    function automatic logic [7:0] pack_status(input logic rdy, input logic idle, input logic ovf);
        logic [7:0] s;
        s           = 8'h00;
        s[StatRdy]  = rdy;
        s[StatIdle] = idle;
        s[StatOvf]  = ovf;
        return s;
    endfunction

endpackage

// File: rtl/ctrl_dec.sv
// Abstract control bus decoder shared by the bus peripherals.
// Layout: [4:0] addr, [5] lower-byte load, [6] upper-byte load, [7] lower read, [8] upper read.
module ctrl_dec (
    input  logic [15:0] ctrl,
    input  logic        sel,
    output logic        ld_ce,
    output logic        ld_t,
    output logic        ud_ce,
    output logic        ud_t,
    output logic [4:0]  addr
);

    logic unused_ctrl;

    assign addr  = ctrl[4:0];
    assign ld_ce = sel & ctrl[5];
    assign ud_ce = sel & ctrl[6];
    // Tristate controls are active-low: 0 means the peripheral drives the bus.
    assign ld_t  = ~(sel & ctrl[7]);
    assign ud_t  = ~(sel & ctrl[8]);

    assign unused_ctrl = ^ctrl[15:9];

endmodule

// File: rtl/xuart_fifo4.sv
// 8-bit x 4 synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module xuart_fifo4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);

    logic [7:0] mem [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] cnt_q;
    logic       do_push, do_pop;

    assign full    = (cnt_q == 3'd4);
    assign empty   = (cnt_q == 3'd0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/xuart_tx.sv
// Byte-wide 8N1 UART transmitter on the abstract control bus with a 4-deep write FIFO.
module xuart_tx
    import xuart_pkg::*;
#(
    parameter int unsigned DIV = 1302
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ctrl,
    input  logic        sel,
    inout  wire  [7:0]  d,
    output logic        tx
);

    localparam logic [15:0] DivMax = 16'(DIV - 1);

    logic        ld_ce, ld_t, ud_ce, ud_t;
    logic [4:0]  addr;
    logic        wr_data, clr_ovf;
    logic        fifo_full, fifo_empty, pop;
    logic [7:0]  fifo_dout;
    logic [2:0]  fifo_count;
    logic        unused_sig;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;
    logic        tick;

    ctrl_dec u_dec (
        .ctrl  (ctrl),
        .sel   (sel),
        .ld_ce (ld_ce),
        .ld_t  (ld_t),
        .ud_ce (ud_ce),
        .ud_t  (ud_t),
        .addr  (addr)
    );

    assign wr_data = ld_ce & ~addr[AddrOvfClr];
    assign clr_ovf = ld_ce & addr[AddrOvfClr];

    xuart_fifo4 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .din   (d),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tick = (state_q != StIdle) && (cnt_q == DivMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: if (tick) state_d = StData;
            StData:  if (tick && bit_q == 3'd7) state_d = StStop;
            StStop: begin
                // Pop straight into the next start bit so frames run back to back.
                if (tick) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (state_q)
            StStart: tx_d = 1'b0;
            StData:  tx_d = sh_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        bit_d = bit_q;
        sh_d  = sh_q;
        if (pop) begin
            cnt_d = 16'd0;
            bit_d = 3'd0;
            sh_d  = fifo_dout;
        end else if (state_q == StIdle) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
            if (tick && state_q == StData) begin
                sh_d  = {1'b0, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
            end
        end
    end

    // A set in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (wr_data && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
            bit_q <= 3'd0;
            sh_q  <= 8'd0;
            tx_q  <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            sh_q  <= sh_d;
            tx_q  <= tx_d;
            ovf_q <= ovf_d;
        end
    end

    assign tx = tx_q;
    assign d  = ld_t ? 8'bz : pack_status(~fifo_full, fifo_empty && (state_q == StIdle), ovf_q);

    assign unused_sig = ^{ud_ce, ud_t, addr[4:1], fifo_count};

endmodule
